// File: rtl/vga_pkg.sv
// Shared VGA definitions: sync polarity levels, standard timing sets and the
// RGB332 -> RGB888 bit-replication expansion used by the scan-out pipeline.
package vga_pkg;

    localparam bit SYNC_ACT_LOW  = 1'b0;
    localparam bit SYNC_ACT_HIGH = 1'b1;

    typedef struct packed {
        int h;
        int hfp;
        int hs;
        int hbp;
        int v;
        int vfp;
        int vs;
        int vbp;
        bit hs_pol;
        bit vs_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x400_70 = '{640, 16, 96, 48, 400, 12, 2, 35,
                                               SYNC_ACT_LOW, SYNC_ACT_HIGH};
    localparam vga_timing_t VGA_640x480_60 = '{640, 16, 96, 48, 480, 10, 2, 33,
                                               SYNC_ACT_LOW, SYNC_ACT_LOW};

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicating the top bits keeps full black and full white exact.
    function automatic rgb888_t rgb332_expand(input logic [7:0] p);
        rgb888_t c;
        c.r = {p[7:5], p[7:5], p[7:6]};
        c.g = {p[4:2], p[4:2], p[4:3]};
        c.b = {4{p[1:0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay with asynchronous clear to RESET_VAL; DEPTH=0 is a
// plain wire so callers can follow the RAM read latency down to zero.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] taps [DEPTH];

            always_ff @(posedge pclk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) taps[i] <= RESET_VAL;
                end else begin
                    taps[0] <= din;
                    for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
                end
            end

            assign dout = taps[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_fb_scanout.sv
// VGA timing generator with framebuffer scan-out and integer pixel replication.
// Optional VGA_TESTPAT_EN adds test_en, replacing RAM data with an address ramp.
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int H      = 640,
    parameter int HFP    = 16,
    parameter int HS     = 96,
    parameter int HBP    = 48,
    parameter int V      = 400,
    parameter int VFP    = 12,
    parameter int VS     = 2,
    parameter int VBP    = 35,
    parameter bit HS_POL = SYNC_ACT_LOW,
    parameter bit VS_POL = SYNC_ACT_HIGH,
    parameter int HSCALE = 4,
    parameter int VSCALE = 4,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 10,
    localparam int FB_W   = H / HSCALE,
    localparam int FB_H   = V / VSCALE,
    localparam int ADDR_W = (FB_W * FB_H > 1) ? $clog2(FB_W * FB_H) : 1
) (
    input  logic              pclk,
    input  logic              reset_n,
`ifdef VGA_TESTPAT_EN
    input  logic              test_en,
`endif
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd,
    input  logic [7:0]        fb_data,
    output logic              hs,
    output logic              vs,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              VGA_HB,
    output logic              VGA_VB,
    output logic              VGA_DE,
    output logic [CNT_W-1:0]  hcount,
    output logic [CNT_W-1:0]  vcount,
    output logic              frame_start
);

    localparam int HSUB_W = (HSCALE > 1) ? $clog2(HSCALE) : 1;
    localparam int VSUB_W = (VSCALE > 1) ? $clog2(VSCALE) : 1;

    localparam logic [CNT_W-1:0]  H_END      = CNT_W'(H + HFP + HS + HBP - 1);
    localparam logic [CNT_W-1:0]  V_END      = CNT_W'(V + VFP + VS + VBP - 1);
    localparam logic [CNT_W-1:0]  H_VIS      = CNT_W'(H);
    localparam logic [CNT_W-1:0]  V_VIS      = CNT_W'(V);
    localparam logic [CNT_W-1:0]  H_LAST_VIS = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0]  V_LAST_VIS = CNT_W'(V - 1);
    localparam logic [CNT_W-1:0]  HS_BEG     = CNT_W'(H + HFP);
    localparam logic [CNT_W-1:0]  HS_FIN     = CNT_W'(H + HFP + HS - 1);
    localparam logic [CNT_W-1:0]  VS_BEG     = CNT_W'(V + VFP);
    localparam logic [CNT_W-1:0]  VS_FIN     = CNT_W'(V + VFP + VS - 1);
    localparam logic [HSUB_W-1:0] HSUB_END   = HSUB_W'(HSCALE - 1);
    localparam logic [VSUB_W-1:0] VSUB_END   = VSUB_W'(VSCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(FB_W);

    generate
        if ((H % HSCALE) != 0 || (V % VSCALE) != 0) begin : g_bad_scale
            $error("vga_fb_scanout: H and V must be integer multiples of HSCALE and VSCALE");
        end
    endgenerate

    logic              test_active;
    logic [CNT_W-1:0]  h_nxt, v_nxt;
    logic              h_wrap, v_wrap, vis_now, vis_nxt, line_end, frame_nxt;

    always_comb begin
        h_wrap    = (hcount == H_END);
        v_wrap    = (vcount == V_END);
        h_nxt     = h_wrap ? '0 : hcount + 1'b1;
        v_nxt     = vcount;
        if (h_wrap) v_nxt = v_wrap ? '0 : vcount + 1'b1;
        vis_now   = (hcount < H_VIS) && (vcount < V_VIS);
        vis_nxt   = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        line_end  = vis_now && (hcount == H_LAST_VIS);
        frame_nxt = (h_nxt == '0) && (v_nxt == '0);
    end

    // Stage 0: counters and raw decodes registered together from the next count
    logic hs_raw, vs_raw, hb_raw, vb_raw;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hcount      <= '0;
            vcount      <= '0;
            fb_rd       <= 1'b0;
            frame_start <= 1'b0;
            hs_raw      <= ~HS_POL;
            vs_raw      <= ~VS_POL;
            hb_raw      <= 1'b1;
            vb_raw      <= 1'b1;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            fb_rd       <= vis_nxt & ~test_active;
            frame_start <= frame_nxt;
            hs_raw      <= ((h_nxt >= HS_BEG) && (h_nxt <= HS_FIN)) ? HS_POL : ~HS_POL;
            vs_raw      <= ((v_nxt >= VS_BEG) && (v_nxt <= VS_FIN)) ? VS_POL : ~VS_POL;
            hb_raw      <= (h_nxt >= H_VIS);
            vb_raw      <= (v_nxt >= V_VIS);
        end
    end

    logic [ADDR_W-1:0] line_base;
    logic [HSUB_W-1:0] hsub;
    logic [VSUB_W-1:0] vsub;

    // The last row wraps straight to 0 so the address never passes FB_W*FB_H-1.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            fb_addr   <= '0;
            line_base <= '0;
            hsub      <= '0;
            vsub      <= '0;
        end else if (frame_nxt) begin
            fb_addr   <= '0;
            line_base <= '0;
            hsub      <= '0;
            vsub      <= '0;
        end else if (line_end) begin
            hsub <= '0;
            if (vsub == VSUB_END) begin
                vsub <= '0;
                if (vcount == V_LAST_VIS) begin
                    line_base <= '0;
                    fb_addr   <= '0;
                end else begin
                    line_base <= line_base + ROW_STEP;
                    fb_addr   <= line_base + ROW_STEP;
                end
            end else begin
                vsub    <= vsub + 1'b1;
                fb_addr <= line_base;
            end
        end else if (vis_now) begin
            if (hsub == HSUB_END) begin
                hsub    <= '0;
                fb_addr <= fb_addr + 1'b1;
            end else begin
                hsub <= hsub + 1'b1;
            end
        end
    end

    logic [7:0] pix;

`ifdef VGA_TESTPAT_EN
    logic [7:0] addr8;
    logic [8:0] tp_d;

    always_comb begin
        addr8 = '0;
        for (int i = 0; i < 8 && i < ADDR_W; i++) addr8[i] = fb_addr[i];
    end

    vga_delay_line #(.WIDTH(9), .DEPTH(RD_LAT), .RESET_VAL(9'd0)) u_tp_dly (
        .pclk    (pclk),
        .reset_n (reset_n),
        .din     ({test_en, addr8}),
        .dout    (tp_d)
    );

    assign test_active = test_en;
    assign pix         = tp_d[8] ? tp_d[7:0] : fb_data;
`else
    assign test_active = 1'b0;
    assign pix         = fb_data;
`endif

    // Stage 1..RD_LAT: control follows the RAM read so it lines up with fb_data
    logic [4:0] ctl_d;

    vga_delay_line #(.WIDTH(5), .DEPTH(RD_LAT),
                     .RESET_VAL({~HS_POL, ~VS_POL, 3'b110})) u_ctl_dly (
        .pclk    (pclk),
        .reset_n (reset_n),
        .din     ({hs_raw, vs_raw, hb_raw, vb_raw, ~(hb_raw | vb_raw)}),
        .dout    (ctl_d)
    );

    rgb888_t px;
    assign px = rgb332_expand(pix);

    // Output stage: colour registered alongside the delayed sync/blank
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hs     <= ~HS_POL;
            vs     <= ~VS_POL;
            VGA_HB <= 1'b1;
            VGA_VB <= 1'b1;
            VGA_DE <= 1'b0;
            r      <= '0;
            g      <= '0;
            b      <= '0;
        end else begin
            {hs, vs, VGA_HB, VGA_VB, VGA_DE} <= ctl_d;
            r <= ctl_d[0] ? px.r : '0;
            g <= ctl_d[0] ? px.g : '0;
            b <= ctl_d[0] ? px.b : '0;
        end
    end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: two small configurations scored cycle by cycle
// against a position-arithmetic model, plus colour-expansion vectors.
module tb_vga_fb_scanout;

    typedef struct packed {
        int h; int hfp; int hs; int hbp;
        int v; int vfp; int vs; int vbp;
        int hsc; int vsc; int lat; int hpol; int vpol;
    } cfg_t;

    typedef struct {
        int hc; int vc; int addr; bit addr_chk; int rd; int fs;
        int hs; int vs; int hb; int vb; int de; int r; int g; int b;
    } exp_t;

    typedef struct {
        logic [7:0] pix; logic [7:0] r; logic [7:0] g; logic [7:0] b;
    } vec_t;

    localparam cfg_t CA = '{8, 2, 2, 2, 4, 1, 1, 1, 2, 2, 1, 0, 1};
    localparam cfg_t CB = '{8, 2, 2, 2, 6, 1, 1, 1, 1, 3, 3, 0, 1};

    logic pclk = 1'b0;
    logic reset_n = 1'b0;
    always #5 pclk = ~pclk;

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_fail = 0;

    logic [2:0] fb_addr_a;
    logic [3:0] fb_addr_b;
    logic       fb_rd_a, fb_rd_b, hs_a, hs_b, vs_a, vs_b;
    logic       hb_a, hb_b, vb_a, vb_b, de_a, de_b, fs_a, fs_b;
    logic [7:0] fb_data_a, fb_data_b, r_a, g_a, b_a, r_b, g_b, b_b;
    logic [3:0] hc_a, vc_a, hc_b, vc_b;

    // Synchronous RAMs: latency 1 for A, latency 3 for B
    logic [7:0] qa;
    logic [7:0] qb [3];
    always @(posedge pclk) qa <= mem[fb_addr_a];
    always @(posedge pclk) begin
        qb[0] <= mem[fb_addr_b];
        qb[1] <= qb[0];
        qb[2] <= qb[1];
    end
    assign fb_data_a = qa;
    assign fb_data_b = qb[2];

    vga_fb_scanout #(.H(8), .HFP(2), .HS(2), .HBP(2), .V(4), .VFP(1), .VS(1), .VBP(1),
                     .HS_POL(1'b0), .VS_POL(1'b1), .HSCALE(2), .VSCALE(2),
                     .RD_LAT(1), .CNT_W(4)) dut_a (
        .pclk(pclk), .reset_n(reset_n), .fb_addr(fb_addr_a), .fb_rd(fb_rd_a),
        .fb_data(fb_data_a), .hs(hs_a), .vs(vs_a), .r(r_a), .g(g_a), .b(b_a),
        .VGA_HB(hb_a), .VGA_VB(vb_a), .VGA_DE(de_a), .hcount(hc_a), .vcount(vc_a),
        .frame_start(fs_a)
    );

    vga_fb_scanout #(.H(8), .HFP(2), .HS(2), .HBP(2), .V(6), .VFP(1), .VS(1), .VBP(1),
                     .HS_POL(1'b0), .VS_POL(1'b1), .HSCALE(1), .VSCALE(3),
                     .RD_LAT(3), .CNT_W(4)) dut_b (
        .pclk(pclk), .reset_n(reset_n), .fb_addr(fb_addr_b), .fb_rd(fb_rd_b),
        .fb_data(fb_data_b), .hs(hs_b), .vs(vs_b), .r(r_b), .g(g_b), .b(b_b),
        .VGA_HB(hb_b), .VGA_VB(vb_b), .VGA_DE(de_b), .hcount(hc_b), .vcount(vc_b),
        .frame_start(fs_b)
    );

    // Expected outputs n cycles after reset release; n=0 is the reset state.
    function automatic exp_t model(input cfg_t c, input int n);
        exp_t e;
        int ht, vt, pos, hh, vv, k, p, c3;
        ht = c.h + c.hfp + c.hs + c.hbp;
        vt = c.v + c.vfp + c.vs + c.vbp;
        pos = n % (ht * vt);
        hh = pos % ht;
        vv = pos / ht;
        e.hc = hh;
        e.vc = vv;
        e.addr_chk = (hh < c.h) && (vv < c.v);
        e.addr = (vv / c.vsc) * (c.h / c.hsc) + hh / c.hsc;
        e.rd = (n >= 1 && e.addr_chk) ? 1 : 0;
        e.fs = (n >= 1 && pos == 0) ? 1 : 0;
        k = n - c.lat - 1;
        e.hs = 1 - c.hpol; e.vs = 1 - c.vpol;
        e.hb = 1; e.vb = 1; e.de = 0; e.r = 0; e.g = 0; e.b = 0;
        if (k >= 1) begin
            pos = k % (ht * vt);
            hh = pos % ht;
            vv = pos / ht;
            if (hh >= c.h + c.hfp && hh < c.h + c.hfp + c.hs) e.hs = c.hpol;
            if (vv >= c.v + c.vfp && vv < c.v + c.vfp + c.vs) e.vs = c.vpol;
            e.hb = (hh >= c.h) ? 1 : 0;
            e.vb = (vv >= c.v) ? 1 : 0;
            e.de = (e.hb == 0 && e.vb == 0) ? 1 : 0;
            if (e.de == 1) begin
                p = int'(mem[(vv / c.vsc) * (c.h / c.hsc) + hh / c.hsc]);
                c3 = p >> 5;
                e.r = (c3 << 5) | (c3 << 2) | (c3 >> 1);
                c3 = (p >> 2) & 7;
                e.g = (c3 << 5) | (c3 << 2) | (c3 >> 1);
                e.b = (p & 3) * 8'h55;
            end
        end
        return e;
    endfunction

    task automatic cmp(input string name, input int n, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    task automatic check_a(input int n);
        exp_t e;
        e = model(CA, n);
        cmp("A.hcount", n, int'(hc_a), e.hc);
        cmp("A.vcount", n, int'(vc_a), e.vc);
        if (e.addr_chk) cmp("A.fb_addr", n, int'(fb_addr_a), e.addr);
        cmp("A.fb_rd", n, int'(fb_rd_a), e.rd);
        cmp("A.frame_start", n, int'(fs_a), e.fs);
        cmp("A.hs", n, int'(hs_a), e.hs);
        cmp("A.vs", n, int'(vs_a), e.vs);
        cmp("A.hb", n, int'(hb_a), e.hb);
        cmp("A.vb", n, int'(vb_a), e.vb);
        cmp("A.de", n, int'(de_a), e.de);
        cmp("A.r", n, int'(r_a), e.r);
        cmp("A.g", n, int'(g_a), e.g);
        cmp("A.b", n, int'(b_a), e.b);
    endtask

    task automatic check_b(input int n);
        exp_t e;
        e = model(CB, n);
        cmp("B.hcount", n, int'(hc_b), e.hc);
        cmp("B.vcount", n, int'(vc_b), e.vc);
        if (e.addr_chk) cmp("B.fb_addr", n, int'(fb_addr_b), e.addr);
        cmp("B.fb_rd", n, int'(fb_rd_b), e.rd);
        cmp("B.frame_start", n, int'(fs_b), e.fs);
        cmp("B.hs", n, int'(hs_b), e.hs);
        cmp("B.vs", n, int'(vs_b), e.vs);
        cmp("B.hb", n, int'(hb_b), e.hb);
        cmp("B.vb", n, int'(vb_b), e.vb);
        cmp("B.de", n, int'(de_b), e.de);
        cmp("B.r", n, int'(r_b), e.r);
        cmp("B.g", n, int'(g_b), e.g);
        cmp("B.b", n, int'(b_b), e.b);
    endtask

    task automatic run_sb(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            check_a(n);
            check_b(n);
            @(negedge pclk);
            #1;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        bit found;
        tbl[0] = '{8'hE3, 8'hFF, 8'h00, 8'hFF};
        tbl[1] = '{8'h1C, 8'h00, 8'hFF, 8'h00};
        tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[4] = '{8'h92, 8'h92, 8'h92, 8'hAA};
        tbl[5] = '{8'h49, 8'h49, 8'h49, 8'h55};

        fill_random();
        reset_n = 1'b0;
        repeat (3) @(negedge pclk);
        #1;
        check_a(0);
        check_b(0);

        @(negedge pclk);
        reset_n = 1'b1;
        #1;
        run_sb(400);

        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (hc_a == 4'd5 && vc_a == 4'd2) found = 1'b1;
            else begin
                @(negedge pclk);
                #1;
            end
        end
        cmp("A.reach_h5_v2", 0, int'(found), 1);

        reset_n = 1'b0;
        #1;
        check_a(0);
        check_b(0);
        fill_random();
        repeat (2) @(negedge pclk);
        reset_n = 1'b1;
        #1;
        run_sb(400);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = tbl[t].pix;
            repeat (6) @(negedge pclk);
            #1;
            found = 1'b0;
            for (int i = 0; i < 200 && !found; i++) begin
                if (de_a) found = 1'b1;
                else begin
                    @(negedge pclk);
                    #1;
                end
            end
            cmp("vec.de_seen", t, int'(found), 1);
            cmp("vec.r", t, int'(r_a), int'(tbl[t].r));
            cmp("vec.g", t, int'(g_a), int'(tbl[t].g));
            cmp("vec.b", t, int'(b_a), int'(tbl[t].b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
